ddr_wr_seq: RTL

- Write sequencer between the LVDS capture path and the DDR write master.
- Buffers the incoming 32-bit LVDS word stream and chops it into fixed-size DDR write bursts into one of two ping-pong buffers.
- Takes its control (select, wd_en, start) from the AXI-Lite register bank.
- Reports progress back to that register bank: start/en/finish strobes, state, write address, FIFO status.

---
 rtl/ddr_wr_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ddr_wr_seq.sv
// ddr_wr_seq: buffers the LVDS word stream and slices it into DDR
// write bursts into one of two ping-pong buffers.
module ddr_wr_seq #(
    parameter int          FIFO_AW   = 9,
    parameter int          BURST_LEN = 16,
    parameter logic [31:0] BASE_A    = 32'h1000_0000,
    parameter logic [31:0] BASE_B    = 32'h1100_0000
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        wd_en,
    input  logic        select,
    input  logic [31:0] start,
    input  logic [31:0] lvds_data,
    input  logic        lvds_data_en,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_addr,
    output logic [7:0]  cmd_len,
    output logic [31:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    output logic        wlast,
    input  logic        bdone,
    output logic        ps_ddr_wr_start,
    output logic        ps_ddr_wr_en,
    output logic        ps_ddr_wr_finish,
    output logic        wt_finish,
    output logic [1:0]  wt_ps_state,
    output logic [31:0] ps_ddr_w_addr,
    output logic [15:0] fifo_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int         DEPTH = 1 << FIFO_AW;
    localparam logic [8:0] BL    = 9'(BURST_LEN);

    state_e             state_q, state_d;
    logic               wd_en_q;
    logic [31:0]        rem_q, rem_d;
    logic [31:0]        addr_q, addr_d;
    logic               ovf_q, ovf_d;
    logic [8:0]         beat_q, beat_d;
    logic               start_q, start_d;

    logic [31:0]        mem_q [DEPTH];
    logic [FIFO_AW:0]   wptr_q, rptr_q;
    logic [FIFO_AW:0]   level;

    logic               rise;
    logic               wr_win;
    logic               full;
    logic               push;
    logic               drop;
    logic               pop;
    logic [8:0]         n_w;
    logic               cmd_ok;
    logic               w_ok;
    logic               beats_done;

    assign rise   = wd_en & ~wd_en_q;
    assign wr_win = (state_q == FILL) || (state_q == BURST);
    assign level  = wptr_q - rptr_q;
    assign full   = level[FIFO_AW];
    assign push   = lvds_data_en & wr_win & ~full;
    assign drop   = lvds_data_en & wr_win & full;

    always_comb begin
        n_w = BL;
        if (rem_q < 32'(BURST_LEN)) begin
            n_w = rem_q[8:0];
        end
    end

    // Level only grows while in FILL, so the command stays stable.
    assign cmd_ok     = (state_q == FILL) && (32'(level) >= {23'd0, n_w});
    assign w_ok       = (state_q == BURST) && (beat_q != n_w);
    assign pop        = w_ok & wready;
    assign beats_done = (state_q == BURST) && (beat_q == n_w);

    always_ff @(posedge s00_axi_aclk) begin
        if (push) begin
            mem_q[wptr_q[FIFO_AW-1:0]] <= lvds_data;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (state_q == DONE) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q | drop;
        beat_d  = beat_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise && (start != 32'd0)) begin
                    rem_d   = start;
                    addr_d  = select ? BASE_B : BASE_A;
                    ovf_d   = 1'b0;
                    start_d = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (cmd_ok && cmd_ready) begin
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (pop) beat_d = beat_q + 9'd1;
                // An early response is ignored until every beat is out.
                if (beats_done && bdone) begin
                    addr_d  = addr_q + {21'd0, n_w, 2'b00};
                    rem_d   = rem_q - {23'd0, n_w};
                    state_d = (rem_q == {23'd0, n_w}) ? DONE : FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q <= IDLE;
            wd_en_q <= 1'b0;
            rem_q   <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            beat_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_en_q <= wd_en;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
            beat_q  <= beat_d;
            start_q <= start_d;
        end
    end

    assign cmd_valid        = cmd_ok;
    assign cmd_addr         = cmd_ok ? addr_q : 32'd0;
    assign cmd_len          = cmd_ok ? 8'(n_w - 9'd1) : 8'd0;
    assign wvalid           = w_ok;
    assign wdata            = w_ok ? mem_q[rptr_q[FIFO_AW-1:0]] : 32'd0;
    assign wlast            = w_ok && (beat_q == (n_w - 9'd1));
    assign ps_ddr_wr_start  = start_q;
    assign ps_ddr_wr_en     = w_ok;
    assign ps_ddr_wr_finish = (state_q == DONE);
    assign wt_finish        = (state_q == DONE);
    assign wt_ps_state      = state_q;
    assign ps_ddr_w_addr    = addr_q;
    assign fifo_state       = {ovf_q, 15'(level)};

endmodule
